// File: rtl/uart_core.sv
// uart_core: parametrised UART transmitter and receiver on one clock.
// TX and RX run independent FSMs; RX input is double-synchronised.
module uart_core #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      CLKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_core: illegal parameter value");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam bit HAS_PAR = (PARITY != 0);

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // ---------------- transmitter ----------------
  state_e               tx_st_q;
  logic                 tx_q;
  logic                 tx_rdy_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic                 tx_par_d;

  assign tx_par_d = (PARITY == 2) ? ^tx_data : ~^tx_data;
  assign tx       = tx_q;
  assign tx_ready = tx_rdy_q;

  // TX frame sequencer; tx line and ready are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= S_IDLE;
      tx_q     <= 1'b1;
      tx_rdy_q <= 1'b1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
    end else begin
      unique case (tx_st_q)
        S_IDLE: begin
          if (tx_valid && tx_rdy_q) begin
            tx_st_q  <= S_START;
            tx_q     <= 1'b0;
            tx_rdy_q <= 1'b0;
            tx_sh_q  <= tx_data;
            tx_par_q <= tx_par_d;
            tx_cnt_q <= '0;
          end
        end
        S_START: begin
          if (tx_cnt_q == C_LAST) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_st_q  <= S_DATA;
            tx_q     <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt_q == C_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == B_LAST) begin
              tx_bit_q <= '0;
              if (HAS_PAR) begin
                tx_st_q <= S_PAR;
                tx_q    <= tx_par_q;
              end else begin
                tx_st_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + BW'(1);
              tx_sh_q  <= tx_sh_q >> 1;
              tx_q     <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        S_PAR: begin
          if (tx_cnt_q == C_LAST) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_st_q  <= S_STOP;
            tx_q     <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt_q == C_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == S_LAST) begin
              tx_bit_q <= '0;
              tx_st_q  <= S_IDLE;
              tx_rdy_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + BW'(1);
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_m_q;
  logic rx_s_q;

  // two-flop synchroniser for the asynchronous rx line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  state_e               rx_st_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_pe_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_perr_q;
  logic                 rx_ferr_q;
  logic                 rx_ovr_q;
  logic                 rx_par_d;

  assign rx_par_d      = (PARITY == 2) ? ^rx_sh_q : ~^rx_sh_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  // RX frame sampler plus output buffer, handshake and overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pe_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end
      unique case (rx_st_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s_q) rx_st_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == C_HALF) begin
            if (rx_s_q) begin
              rx_st_q <= S_IDLE;
            end else begin
              rx_cnt_q <= '0;
              rx_bit_q <= '0;
              rx_pe_q  <= 1'b0;
              rx_st_q  <= S_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt_q == C_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == B_LAST) begin
              rx_bit_q <= '0;
              rx_st_q  <= HAS_PAR ? S_PAR : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + BW'(1);
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        S_PAR: begin
          if (rx_cnt_q == C_LAST) begin
            rx_cnt_q <= '0;
            rx_pe_q  <= rx_s_q ^ rx_par_d;
            rx_st_q  <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt_q == C_LAST) begin
            rx_cnt_q <= '0;
            rx_st_q  <= S_IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= rx_sh_q;
              rx_perr_q  <= HAS_PAR ? rx_pe_q : 1'b0;
              rx_ferr_q  <= ~rx_s_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_ovr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core TX waveform and RX path.
// Three instances cover no parity, even parity/2 stops and odd parity.
module tb_uart_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] tx_data0, tx_data1, tx_data2;
  logic tx_valid0, tx_valid1, tx_valid2;
  logic tx_ready0, tx_ready1, tx_ready2;
  logic tx0, tx1, tx2;
  logic rx0, rx1, rx2;
  logic [7:0] rx_data0, rx_data1, rx_data2;
  logic rx_valid0, rx_valid1, rx_valid2;
  logic rx_ready0, rx_ready1, rx_ready2;
  logic perr0, perr1, perr2;
  logic ferr0, ferr1, ferr2;
  logic ovr0, ovr1, ovr2;

  logic loop0, loop1, rxd0, rxd1;
  assign rx0 = loop0 ? tx0 : rxd0;
  assign rx1 = loop1 ? tx1 : rxd1;
  assign rx2 = tx2;

  uart_core #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(8)
  ) u0 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx(tx0), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_overrun(ovr0)
  );

  uart_core #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(8)
  ) u1 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx(tx1), .rx(rx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overrun(ovr1)
  );

  uart_core #(
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(8)
  ) u2 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx(tx2), .rx(rx2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .rx_parity_err(perr2), .rx_frame_err(ferr2), .rx_overrun(ovr2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_low;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(int u);
    case (u)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic get_rdy(int u);
    case (u)
      0: return tx_ready0;
      1: return tx_ready1;
      default: return tx_ready2;
    endcase
  endfunction

  function automatic logic get_rxv(int u);
    case (u)
      0: return rx_valid0;
      1: return rx_valid1;
      default: return rx_valid2;
    endcase
  endfunction

  function automatic logic [7:0] get_rxd(int u);
    case (u)
      0: return rx_data0;
      1: return rx_data1;
      default: return rx_data2;
    endcase
  endfunction

  function automatic logic get_perr(int u);
    case (u)
      0: return perr0;
      1: return perr1;
      default: return perr2;
    endcase
  endfunction

  function automatic logic get_ferr(int u);
    case (u)
      0: return ferr0;
      1: return ferr1;
      default: return ferr2;
    endcase
  endfunction

  function automatic logic get_ovr(int u);
    case (u)
      0: return ovr0;
      1: return ovr1;
      default: return ovr2;
    endcase
  endfunction

  task automatic set_txv(int u, logic v, logic [7:0] d);
    case (u)
      0: begin tx_valid0 = v; tx_data0 = d; end
      1: begin tx_valid1 = v; tx_data1 = d; end
      default: begin tx_valid2 = v; tx_data2 = d; end
    endcase
  endtask

  task automatic set_rxr(int u, logic v);
    if (u == 0) rx_ready0 = v;
    else rx_ready1 = v;
  endtask

  task automatic set_rxd(int u, logic v);
    if (u == 0) rxd0 = v;
    else rxd1 = v;
  endtask

  task automatic send(int u, logic [7:0] d);
    chk($sformatf("tx_ready%0d before send", u), get_rdy(u), 1);
    set_txv(u, 1'b1, d);
    @(posedge clk);
    #1;
    set_txv(u, 1'b0, 8'h00);
  endtask

  // Called one step after the accepting edge P0.
  task automatic watch_tx(int u, logic [7:0] d, bit hp, logic pb,
                          int ns);
    int highs;
    chk($sformatf("tx%0d low after accept", u), get_tx(u), 0);
    chk($sformatf("tx_ready%0d low after accept", u), get_rdy(u), 0);
    step(4);
    chk($sformatf("tx%0d start bit", u), get_tx(u), 0);
    for (int i = 0; i < 8; i++) begin
      step(8);
      chk($sformatf("tx%0d data bit %0d", u, i), get_tx(u), d[i]);
    end
    if (hp) begin
      step(8);
      chk($sformatf("tx%0d parity bit", u), get_tx(u), pb);
    end
    step(4);
    highs = 0;
    for (int j = 0; j < ns * 8; j++) begin
      if (get_tx(u)) highs++;
      if (j != ns * 8 - 1) step(1);
    end
    chk($sformatf("tx%0d stop high cycles", u), highs, ns * 8);
    chk($sformatf("tx_ready%0d low at last cycle", u), get_rdy(u), 0);
    step(1);
    chk($sformatf("tx_ready%0d after frame", u), get_rdy(u), 1);
  endtask

  task automatic wait_rx(int u);
    int n = 0;
    while (!get_rxv(u) && n < 300) begin
      step(1);
      n++;
    end
    chk($sformatf("rx_valid%0d arrives", u), get_rxv(u), 1);
  endtask

  task automatic consume(int u);
    set_rxr(u, 1'b1);
    step(1);
    set_rxr(u, 1'b0);
    chk($sformatf("rx_valid%0d after consume", u), get_rxv(u), 0);
    chk($sformatf("rx_overrun%0d after consume", u), get_ovr(u), 0);
  endtask

  task automatic drive_frame(int u, logic [7:0] d, bit hp, logic pb,
                             logic stopv, int ns);
    set_rxd(u, 1'b0);
    step(8);
    for (int i = 0; i < 8; i++) begin
      set_rxd(u, d[i]);
      step(8);
    end
    if (hp) begin
      set_rxd(u, pb);
      step(8);
    end
    set_rxd(u, stopv);
    step(8);
    for (int s = 1; s < ns; s++) begin
      set_rxd(u, 1'b1);
      step(8);
    end
    set_rxd(u, 1'b1);
    step(12);
  endtask

  initial begin
    int n;
    int seen;
    vecs[0] = '{din: 8'h00, exp_data: 8'h00, exp_low: 80,
                exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{din: 8'hFF, exp_data: 8'hFF, exp_low: 80,
                exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{din: 8'h3C, exp_data: 8'h3C, exp_low: 80,
                exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{din: 8'h81, exp_data: 8'h81, exp_low: 80,
                exp_perr: 1'b0, exp_ferr: 1'b0};

    rst = 1'b1;
    tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0;
    tx_data0 = 8'h00; tx_data1 = 8'h00; tx_data2 = 8'h00;
    rx_ready0 = 1'b0; rx_ready1 = 1'b0; rx_ready2 = 1'b1;
    loop0 = 1'b1; loop1 = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1;
    step(3);
    rst = 1'b0;

    chk("reset tx", tx0, 1);
    chk("reset tx_ready", tx_ready0, 1);
    chk("reset rx_valid", rx_valid0, 0);
    chk("reset rx_data", rx_data0, 8'h00);
    chk("reset parity_err", perr0, 0);
    chk("reset frame_err", ferr0, 0);
    chk("reset overrun", ovr0, 0);
    step(2);

    // loopback 0xA5 with full waveform check
    send(0, 8'hA5);
    watch_tx(0, 8'hA5, 1'b0, 1'b0, 1);
    wait_rx(0);
    chk("loop A5 data", rx_data0, 8'hA5);
    chk("loop A5 perr", perr0, 0);
    chk("loop A5 ferr", ferr0, 0);
    chk("loop A5 overrun", ovr0, 0);
    consume(0);

    // table-driven loopback frames
    for (int v = 0; v < 4; v++) begin
      send(0, vecs[v].din);
      n = 0;
      while (!tx_ready0 && n < 300) begin
        step(1);
        n++;
      end
      chk($sformatf("vec%0d tx_ready low cycles", v), n, vecs[v].exp_low);
      wait_rx(0);
      chk($sformatf("vec%0d rx_data", v), rx_data0, vecs[v].exp_data);
      chk($sformatf("vec%0d perr", v), perr0, vecs[v].exp_perr);
      chk($sformatf("vec%0d ferr", v), ferr0, vecs[v].exp_ferr);
      consume(0);
    end

    // parity bits: even -> 1, odd -> 0 for 0x07
    send(1, 8'h07);
    watch_tx(1, 8'h07, 1'b1, 1'b1, 2);
    wait_rx(1);
    chk("even loop 07 data", rx_data1, 8'h07);
    chk("even loop 07 perr", perr1, 0);
    consume(1);
    send(2, 8'h07);
    watch_tx(2, 8'h07, 1'b1, 1'b0, 1);

    // injected parity error
    loop1 = 1'b0;
    drive_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 2);
    wait_rx(1);
    chk("bad parity data", rx_data1, 8'h07);
    chk("bad parity perr", perr1, 1);
    chk("bad parity ferr", ferr1, 0);
    consume(1);

    // framing error then a clean frame
    loop0 = 1'b0;
    drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
    wait_rx(0);
    chk("frame err data", rx_data0, 8'h5A);
    chk("frame err ferr", ferr0, 1);
    consume(0);
    drive_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, 1);
    wait_rx(0);
    chk("clean 33 data", rx_data0, 8'h33);
    chk("clean 33 ferr", ferr0, 0);
    consume(0);

    // overrun
    drive_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1);
    drive_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
    chk("overrun rx_valid", rx_valid0, 1);
    chk("overrun keeps data", rx_data0, 8'h11);
    chk("overrun flag", ovr0, 1);
    consume(0);

    // glitch rejection
    rxd0 = 1'b0;
    step(2);
    rxd0 = 1'b1;
    seen = 0;
    for (int k = 0; k < 120; k++) begin
      if (rx_valid0) seen++;
      step(1);
    end
    chk("glitch no rx_valid", seen, 0);
    drive_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1);
    wait_rx(0);
    chk("after glitch data", rx_data0, 8'hC3);
    chk("after glitch ferr", ferr0, 0);
    consume(0);

    // reset during data bit 3
    loop0 = 1'b1;
    send(0, 8'h00);
    step(34);
    chk("tx during bit 3", tx0, 0);
    rst = 1'b1;
    step(1);
    chk("mid-frame reset tx", tx0, 1);
    chk("mid-frame reset tx_ready", tx_ready0, 1);
    chk("mid-frame reset rx_valid", rx_valid0, 0);
    rst = 1'b0;
    step(4);

    // two stop bits, even parity of 0x3C is 0
    loop1 = 1'b1;
    send(1, 8'h3C);
    watch_tx(1, 8'h3C, 1'b1, 1'b0, 2);
    wait_rx(1);
    chk("stop2 3C data", rx_data1, 8'h3C);
    chk("stop2 3C perr", perr1, 0);
    chk("stop2 3C ferr", ferr1, 0);
    consume(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
